// File: rtl/capture_scheduler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : capture_scheduler_pkg
// Description : IAGC status codes shared with the sampler and top-level
//               controller, plus the capture scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package capture_scheduler_pkg;

    localparam int         c_IAGC_W      = 4;
    localparam logic [3:0] c_IAGC_RESET  = 4'b0000;
    localparam logic [3:0] c_IAGC_SAMPLE = 4'b0011;
    localparam logic [3:0] c_IAGC_HALT   = 4'b1100;

    localparam int                   c_STATE_W    = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE    = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_START   = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_RUN     = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ST_DRAIN   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/capture_scheduler_decimator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : capture_scheduler_decimator
// Description : Keeps one of every N valid strobes; factor 0 behaves as 1.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_scheduler_decimator #(
    parameter int DEC_SIZE = 16
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic                i_valid,
    input  logic [DEC_SIZE-1:0] i_factor,
    input  logic                i_enable,
    input  logic                i_preset,
    output logic                o_fire,
    output logic                o_strobe
);

    localparam logic [DEC_SIZE-1:0] c_ONE = DEC_SIZE'(1);

    logic [DEC_SIZE-1:0] r_phase;
    logic [DEC_SIZE-1:0] w_last;
    logic                r_strobe;

    assign w_last   = (i_factor == '0) ? '0 : (i_factor - c_ONE);
    assign o_fire   = i_enable && i_valid && (r_phase == w_last);
    assign o_strobe = r_strobe;

    // Preset parks the phase on its last value so the first valid fires.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_phase  <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= o_fire;
            if (i_preset) begin
                r_phase <= w_last;
            end else if (i_enable && i_valid) begin
                r_phase <= o_fire ? '0 : (r_phase + c_ONE);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/capture_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : capture_scheduler
// Description : Sequences an ADC capture: configuration latch, decimated
//               sample strobe, drain/timeout handling and sampler status.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_scheduler
    import capture_scheduler_pkg::*;
#(
    parameter int ADDR_SIZE        = 12,
    parameter int DEC_SIZE         = 16,
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int DRAIN_TIMEOUT    = 8
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic                        i_set_mem,
    input  logic [ADDR_SIZE-1:0]        i_mem_size,
    input  logic                        i_set_dec,
    input  logic [DEC_SIZE-1:0]         i_decimation,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic                        i_adc_valid,
    input  logic                        i_sampler_end,
    output logic [IAGC_STATUS_SIZE-1:0] o_sampler_status,
    output logic                        o_sample,
    output logic [ADDR_SIZE-1:0]        o_mem_size,
    output logic [ADDR_SIZE:0]          o_sample_count,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_error,
    output logic                        o_aborted
);

    localparam int                   c_DRAIN_W    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);
    localparam logic [ADDR_SIZE:0]   c_COUNT_ONE  = (ADDR_SIZE + 1)'(1);
    localparam logic [DEC_SIZE-1:0]  c_DEC_ONE    = DEC_SIZE'(1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [ADDR_SIZE-1:0] r_mem_size;
    logic [ADDR_SIZE-1:0] r_run_limit;
    logic [DEC_SIZE-1:0]  r_decimation;
    logic [ADDR_SIZE:0]   r_count;
    logic [c_DRAIN_W-1:0] r_drain_cnt;
    logic                 r_done;
    logic                 r_error;
    logic                 r_aborted;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_error;
    logic                 w_aborted;
    logic                 w_enable;
    logic                 w_fire;
    logic                 w_last_strobe;

    assign w_enable      = (r_state == c_ST_RUN) && !i_abort;
    assign w_last_strobe = w_fire && ((r_count + c_COUNT_ONE) == {1'b0, r_run_limit});

    capture_scheduler_decimator #(
        .DEC_SIZE (DEC_SIZE)
    ) u_decimator (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_valid   (i_adc_valid),
        .i_factor  (r_decimation),
        .i_enable  (w_enable),
        .i_preset  (w_accept),
        .o_fire    (w_fire),
        .o_strobe  (o_sample)
    );

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_error      = 1'b0;
        w_aborted    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (i_start) begin
                    if (r_mem_size == '0) begin
                        w_error = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = c_ST_START;
                    end
                end
            end
            c_ST_START: begin
                if (i_abort) begin
                    w_aborted    = 1'b1;
                    w_next_state = c_ST_IDLE;
                end else begin
                    w_next_state = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (i_abort) begin
                    w_aborted    = 1'b1;
                    w_next_state = c_ST_IDLE;
                end else if (w_last_strobe) begin
                    w_next_state = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                // Abort outranks both end and timeout.
                if (i_abort) begin
                    w_aborted    = 1'b1;
                    w_next_state = c_ST_IDLE;
                end else if (i_sampler_end) begin
                    w_done       = 1'b1;
                    w_next_state = c_ST_IDLE;
                end else if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_error      = 1'b1;
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= c_ST_IDLE;
            r_mem_size   <= '1;
            r_run_limit  <= '1;
            r_decimation <= c_DEC_ONE;
            r_count      <= '0;
            r_drain_cnt  <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_done    <= w_done;
            r_error   <= w_error;
            r_aborted <= w_aborted;
            if (r_state == c_ST_IDLE) begin
                if (i_set_mem) r_mem_size   <= i_mem_size;
                if (i_set_dec) r_decimation <= i_decimation;
            end
            // The run limit snapshots the size seen by start, so a same-cycle
            // set only affects the following capture.
            if (w_accept) begin
                r_count     <= '0;
                r_run_limit <= r_mem_size;
            end else if (w_fire) begin
                r_count <= r_count + c_COUNT_ONE;
            end
            r_drain_cnt <= (r_state == c_ST_DRAIN) ? (r_drain_cnt + c_DRAIN_ONE) : '0;
        end
    end

    assign o_sampler_status = (r_state == c_ST_IDLE) ? IAGC_STATUS_SIZE'(c_IAGC_RESET)
                                                     : IAGC_STATUS_SIZE'(c_IAGC_SAMPLE);
    assign o_mem_size       = r_mem_size;
    assign o_sample_count   = r_count;
    assign o_busy           = (r_state != c_ST_IDLE);
    assign o_done           = r_done;
    assign o_error          = r_error;
    assign o_aborted        = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_capture_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_capture_scheduler
// Description : Directed self-checking bench for capture_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_scheduler;

    logic        i_clock = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_set_mem = 1'b0;
    logic [11:0] i_mem_size = '0;
    logic        i_set_dec = 1'b0;
    logic [15:0] i_decimation = '0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_adc_valid = 1'b0;
    logic        i_sampler_end = 1'b0;
    logic [3:0]  o_sampler_status;
    logic        o_sample;
    logic [11:0] o_mem_size;
    logic [12:0] o_sample_count;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic        o_aborted;

    int n_cmp  = 0;
    int n_fail = 0;

    capture_scheduler #(
        .ADDR_SIZE        (12),
        .DEC_SIZE         (16),
        .IAGC_STATUS_SIZE (4),
        .DRAIN_TIMEOUT    (8)
    ) dut (
        .i_clock          (i_clock),
        .i_reset_n        (i_reset_n),
        .i_set_mem        (i_set_mem),
        .i_mem_size       (i_mem_size),
        .i_set_dec        (i_set_dec),
        .i_decimation     (i_decimation),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .i_adc_valid      (i_adc_valid),
        .i_sampler_end    (i_sampler_end),
        .o_sampler_status (o_sampler_status),
        .o_sample         (o_sample),
        .o_mem_size       (o_mem_size),
        .o_sample_count   (o_sample_count),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_error          (o_error),
        .o_aborted        (o_aborted)
    );

    always #5 i_clock = ~i_clock;

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic configure(input int mem, input int dec);
        i_set_mem = 1'b1; i_mem_size = 12'(mem);
        i_set_dec = 1'b1; i_decimation = 16'(dec);
        step();
        i_set_mem = 1'b0; i_set_dec = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        step(); step();
        n_cmp++; if (o_sampler_status !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %b want 0000", o_sampler_status); end
        n_cmp++; if (o_sample !== 1'b0) begin n_fail++; $display("FAIL reset_sample: got %b want 0", o_sample); end
        n_cmp++; if (o_mem_size !== 12'hFFF) begin n_fail++; $display("FAIL reset_mem: got %h want fff", o_mem_size); end
        n_cmp++; if (o_sample_count !== 13'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_sample_count); end
        n_cmp++; if ({o_busy, o_done, o_error, o_aborted} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {o_busy, o_done, o_error, o_aborted}); end
        i_reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        configure(4, 1);
        n_cmp++; if (o_mem_size !== 12'd4) begin n_fail++; $display("FAIL basic_mem: got %0d want 4", o_mem_size); end
        i_start = 1'b1; step(); i_start = 1'b0;
        n_cmp++; if (o_busy !== 1'b1 || o_sampler_status !== 4'b0011) begin n_fail++; $display("FAIL basic_start: got busy %b status %b want 1 0011", o_busy, o_sampler_status); end
        i_adc_valid = 1'b1;
        step();
        n_cmp++; if (o_sample !== 1'b0) begin n_fail++; $display("FAIL basic_start_valid: got %b want 0", o_sample); end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++; if (o_sample !== 1'b1 || o_sample_count !== 13'(i)) begin n_fail++; $display("FAIL basic_strobe%0d: got %b/%0d want 1/%0d", i, o_sample, o_sample_count, i); end
        end
        i_adc_valid = 1'b0;
        step();
        n_cmp++; if (o_sample !== 1'b0 || o_busy !== 1'b1 || o_sampler_status !== 4'b0011) begin n_fail++; $display("FAIL basic_drain: got %b/%b/%b want 0/1/0011", o_sample, o_busy, o_sampler_status); end
        step();
        i_sampler_end = 1'b1; step(); i_sampler_end = 1'b0;
        n_cmp++; if (o_done !== 1'b1 || o_sampler_status !== 4'b0000 || o_sample_count !== 13'd4 || o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: got done %b status %b count %0d busy %b want 1 0000 4 0", o_done, o_sampler_status, o_sample_count, o_busy); end
        step();
        n_cmp++; if (o_done !== 1'b0 || o_sample_count !== 13'd4) begin n_fail++; $display("FAIL basic_done_pulse: got %b/%0d want 0/4", o_done, o_sample_count); end
    endtask

    task automatic test_decimation();
        int exp_cnt;
        logic exp_s;
        configure(3, 4);
        i_start = 1'b1; step(); i_start = 1'b0;
        i_adc_valid = 1'b1;
        exp_cnt = 0;
        for (int j = 0; j < 12; j++) begin
            step();
            exp_s = (j == 1) || (j == 5) || (j == 9);
            if (exp_s) exp_cnt++;
            n_cmp++; if (o_sample !== exp_s || o_sample_count !== 13'(exp_cnt)) begin n_fail++; $display("FAIL dec4_edge%0d: got %b/%0d want %b/%0d", j, o_sample, o_sample_count, exp_s, exp_cnt); end
        end
        n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL dec4_drain_busy: got %b want 1", o_busy); end
        i_adc_valid = 1'b0;
        i_sampler_end = 1'b1; step(); i_sampler_end = 1'b0;
        n_cmp++; if (o_done !== 1'b1 || o_sample_count !== 13'd3) begin n_fail++; $display("FAIL dec4_done: got %b/%0d want 1/3", o_done, o_sample_count); end
        step();
    endtask

    task automatic test_dec_zero_and_reject();
        configure(0, 0);
        i_start = 1'b1; step(); i_start = 1'b0;
        n_cmp++; if (o_error !== 1'b1 || o_busy !== 1'b0 || o_sampler_status !== 4'b0000) begin n_fail++; $display("FAIL reject_zero: got err %b busy %b status %b want 1 0 0000", o_error, o_busy, o_sampler_status); end
        step();
        n_cmp++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL reject_pulse: got %b want 0", o_error); end
        i_set_mem = 1'b1; i_mem_size = 12'd2; i_start = 1'b1;
        step();
        i_set_mem = 1'b0; i_start = 1'b0;
        n_cmp++; if (o_error !== 1'b1 || o_busy !== 1'b0 || o_mem_size !== 12'd2) begin n_fail++; $display("FAIL same_cycle_set: got err %b busy %b mem %0d want 1 0 2", o_error, o_busy, o_mem_size); end
        step();
        i_start = 1'b1; step(); i_start = 1'b0;
        n_cmp++; if (o_busy !== 1'b1 || o_error !== 1'b0) begin n_fail++; $display("FAIL dec0_accept: got busy %b err %b want 1 0", o_busy, o_error); end
        i_adc_valid = 1'b1;
        step();
        for (int i = 1; i <= 2; i++) begin
            step();
            n_cmp++; if (o_sample !== 1'b1 || o_sample_count !== 13'(i)) begin n_fail++; $display("FAIL dec0_strobe%0d: got %b/%0d want 1/%0d", i, o_sample, o_sample_count, i); end
        end
        step();
        n_cmp++; if (o_sample !== 1'b0 || o_sample_count !== 13'd2) begin n_fail++; $display("FAIL dec0_drain: got %b/%0d want 0/2", o_sample, o_sample_count); end
        i_adc_valid = 1'b0;
        i_sampler_end = 1'b1; step(); i_sampler_end = 1'b0;
        n_cmp++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL dec0_done: got %b want 1", o_done); end
        step();
    endtask

    task automatic test_abort();
        configure(8, 1);
        i_start = 1'b1; step(); i_start = 1'b0;
        i_adc_valid = 1'b1;
        step(); step(); step();
        n_cmp++; if (o_sample_count !== 13'd2) begin n_fail++; $display("FAIL abort_precount: got %0d want 2", o_sample_count); end
        i_abort = 1'b1; step(); i_abort = 1'b0;
        n_cmp++; if (o_aborted !== 1'b1 || o_sample !== 1'b0 || o_busy !== 1'b0 || o_sampler_status !== 4'b0000 || o_done !== 1'b0 || o_sample_count !== 13'd2) begin n_fail++; $display("FAIL abort_run: got ab %b s %b busy %b st %b done %b cnt %0d want 1 0 0 0000 0 2", o_aborted, o_sample, o_busy, o_sampler_status, o_done, o_sample_count); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (o_sample !== 1'b0 || o_done !== 1'b0 || o_aborted !== 1'b0) begin n_fail++; $display("FAIL abort_after%0d: got s %b done %b ab %b want 0 0 0", i, o_sample, o_done, o_aborted); end
        end
        i_adc_valid = 1'b0;
        i_abort = 1'b1; step(); i_abort = 1'b0;
        n_cmp++; if (o_aborted !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b want 0", o_aborted); end
    endtask

    task automatic test_timeout();
        configure(1, 1);
        i_start = 1'b1; step(); i_start = 1'b0;
        i_adc_valid = 1'b1;
        step(); step();
        i_adc_valid = 1'b0;
        n_cmp++; if (o_sample !== 1'b1 || o_sample_count !== 13'd1) begin n_fail++; $display("FAIL timeout_strobe: got %b/%0d want 1/1", o_sample, o_sample_count); end
        for (int k = 1; k <= 7; k++) begin
            step();
            n_cmp++; if (o_error !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL timeout_wait%0d: got err %b busy %b want 0 1", k, o_error, o_busy); end
        end
        step();
        n_cmp++; if (o_error !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_sampler_status !== 4'b0000) begin n_fail++; $display("FAIL timeout_fire: got err %b busy %b done %b st %b want 1 0 0 0000", o_error, o_busy, o_done, o_sampler_status); end
        step();
        n_cmp++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b want 0", o_error); end
    endtask

    task automatic test_ignore_and_async_reset();
        configure(8, 1);
        i_start = 1'b1; step(); i_start = 1'b0;
        i_adc_valid = 1'b1;
        step(); step();
        i_set_mem = 1'b1; i_mem_size = 12'd3;
        i_set_dec = 1'b1; i_decimation = 16'd5;
        i_start = 1'b1;
        step();
        i_set_mem = 1'b0; i_set_dec = 1'b0; i_start = 1'b0;
        n_cmp++; if (o_mem_size !== 12'd8 || o_sample !== 1'b1 || o_sample_count !== 13'd2 || o_busy !== 1'b1 || o_error !== 1'b0) begin n_fail++; $display("FAIL busy_ignore: got mem %0d s %b cnt %0d busy %b err %b want 8 1 2 1 0", o_mem_size, o_sample, o_sample_count, o_busy, o_error); end
        step();
        n_cmp++; if (o_sample !== 1'b1 || o_sample_count !== 13'd3) begin n_fail++; $display("FAIL busy_dec_kept: got %b/%0d want 1/3", o_sample, o_sample_count); end
        #2;
        i_reset_n = 1'b0;
        #1;
        n_cmp++; if (o_sample !== 1'b0 || o_sampler_status !== 4'b0000 || o_busy !== 1'b0 || o_sample_count !== 13'd0 || o_mem_size !== 12'hFFF || {o_done, o_error, o_aborted} !== 3'b000) begin n_fail++; $display("FAIL async_reset: got s %b st %b busy %b cnt %0d mem %h flags %b want 0 0000 0 0 fff 000", o_sample, o_sampler_status, o_busy, o_sample_count, o_mem_size, {o_done, o_error, o_aborted}); end
        i_adc_valid = 1'b0;
        step();
        i_reset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_decimation();
        test_dec_zero_and_reject();
        test_abort();
        test_timeout();
        test_ignore_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
